mc_mem_responder: RTL and testbench
===================================

// Module: mc_mem_responder
// PURPOSE
//  Memory-side end of the multicycle core's unified instruction/data memory port.
//  Accepts one word read or write request at a time over a valid/ready handshake.
//  Inserts LATENCY programmable wait states, then holds a response until the core takes it.
//  Sits between the multicycle datapath's address mux (PC or ALU result) and the word-addressed storage array.
// PARAMETERS
//  DATA_W   32    data word width; byte strobes are DATA_W/8 wide
//  DEPTH    1024  number of words in the storage array
//  LATENCY  2     wait cycles between acceptance and response, range 0..15
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset (0 = reset)
//  req_valid  in   1       request present
//  req_ready  out  1       responder can accept a request
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   32      byte address; must be word aligned
//  req_wdata  in   DATA_W  write data
//  req_wstrb  in   DATA_W/8  byte-lane write enables; ignored on reads
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       core takes the response
//  rsp_rdata  out  DATA_W  read data; 0 for writes and errors
//  rsp_err    out  1       misaligned or out-of-range request
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0. req_ready=0 while rst=0. rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  Reset leaves array contents undefined; it is not cleared.
//  FSM states:
//   IDLE: req_ready=1.
//    On req_valid&req_ready, capture we/addr/wdata/wstrb.
//    Next state is WAIT (counter=LATENCY-1) if LATENCY>0, otherwise RESP.
//   WAIT: req_ready=0. Counter decrements each cycle. Go to RESP on the edge where counter==0.
//   RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until the handshake completes.
//    On rsp_ready go to IDLE. rsp_valid falls and req_ready rises in the next cycle.
//  Timing:
//   rsp_valid is first high in cycle LATENCY+1 after the accepting edge.
//   No back-to-back acceptance in one cycle; min request period = LATENCY+2 cycles.
//  Error check:
//   Error when req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH. Evaluated at acceptance.
//   On error: no array write, rsp_err=1, rsp_rdata=0. Response timing is unchanged.
//  Write:
//   Committed at the accepting edge, one byte lane per set req_wstrb bit.
//   wstrb=0 writes nothing but still returns a response.
//  Read:
//   Array word sampled on the edge entering RESP, so it reflects all earlier committed writes.
//   Held in a register for the whole RESP phase.
//  Inputs are don't-care outside IDLE; req_valid during WAIT/RESP is ignored, not queued.
//  Reset mid-operation:
//   Returns to IDLE and drops any pending response.
//   A write already committed at acceptance persists.
//  LATENCY>15 is illegal; an elaboration-time check must fail the build.
// TESTING
//  1. LATENCY=2. Write 0xDEADBEEF to 0x10 (wstrb=1111), rsp_ready=1.
//     -> rsp_valid high exactly 3 cycles after accept, err=0, rdata=0.
//     Then read 0x10 -> rdata=0xDEADBEEF.
//  2. Partial write: wstrb=0010, wdata=0x0000AA00 to 0x10.
//     -> subsequent read of 0x10 returns 0xDEADAAEF.
//  3. Read 0x12 (misaligned), then read of address 4*DEPTH.
//     -> both give rsp_err=1, rdata=0, normal timing.
//     Array is unchanged, confirmed by re-reading 0x10.
//  4. Backpressure: hold rsp_ready=0 for 5 cycles in RESP.
//     -> rsp_valid, rdata and err stay stable; req_ready=0 and a new req_valid is not accepted.
//     Release rsp_ready -> req_ready=1 on the next cycle.
//  5. LATENCY=0 build: a read is answered on the cycle after acceptance.
//     Streaming 4 reads with rsp_ready=1 -> one accept every 2 cycles.
//  6. Assert rst low during WAIT of a write to 0x20.
//     -> rsp_valid=0 immediately, state IDLE.
//     After release, reading 0x20 returns the new data.

Source files
------------

// File: rtl/mc_mem_responder.sv
// mc_mem_responder
// Memory-side end of the multicycle core's unified instruction/data port.
// One word request is accepted at a time. The responder inserts LATENCY wait
// states and then holds the response until the core takes it.
// Storage is one byte-wide array per lane, so each write strobe maps onto its
// own RAM write enable. Every array uses a registered read.
module mc_mem_responder #(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_wstrb,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err
);

   localparam int NLANE = DATA_W / 8;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   // The wait counter is only 4 bits wide, so a larger latency cannot be built.
   generate
      if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
         $error("mc_mem_responder: LATENCY must be in 0..15");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [3:0]      cnt_reg, cnt_next;

   // Request attributes captured at acceptance. Write data and strobes are
   // not kept: the write is already committed at the accepting edge.
   logic            we_reg;
   logic            err_reg;
   logic [AW-1:0]   idx_reg;
   logic            rd_ok_reg;

   logic            accept;
   logic            addr_err;
   logic [AW-1:0]   req_idx;
   logic [AW-1:0]   rd_idx;
   logic            cur_err;
   logic            cur_we;
   logic            enter_resp;
   logic            rd_en;
   logic [DATA_W-1:0] rd_word;

   assign accept   = req_valid & req_ready;
   assign addr_err = (req_addr[1:0] != 2'b00) ||
                     ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
   assign req_idx  = req_addr[AW+1:2];

   // With LATENCY=0 the accepting edge is also the edge entering RESP.
   // In that case the read must use the live request rather than the capture.
   assign rd_idx   = (state_reg == ST_IDLE) ? req_idx  : idx_reg;
   assign cur_err  = (state_reg == ST_IDLE) ? addr_err : err_reg;
   assign cur_we   = (state_reg == ST_IDLE) ? req_we   : we_reg;

   assign enter_resp = (state_reg != ST_RESP) && (state_next == ST_RESP);
   assign rd_en      = enter_resp && !cur_err && !cur_we;

   // State register and wait counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state logic: accept in IDLE, count down in WAIT, hold RESP until taken.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      unique case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               if (LATENCY > 0) begin
                  state_next = ST_WAIT;
                  cnt_next   = LAT_M1;
               end else begin
                  state_next = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = ST_RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Output decode. Read data is forced to zero for writes and errors.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      unique case (state_reg)
         ST_IDLE: req_ready = rst;
         ST_RESP: begin
            rsp_valid = 1'b1;
            rsp_err   = err_reg;
            rsp_rdata = rd_ok_reg ? rd_word : '0;
         end
         default: ;
      endcase
   end

   // Capture the request at acceptance. Record on RESP entry whether read data is valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_reg    <= 1'b0;
         err_reg   <= 1'b0;
         idx_reg   <= '0;
         rd_ok_reg <= 1'b0;
      end else begin
         if (accept) begin
            we_reg  <= req_we;
            err_reg <= addr_err;
            idx_reg <= req_idx;
         end
         if (enter_resp) begin
            rd_ok_reg <= !cur_err && !cur_we;
         end
      end
   end

   // One byte-wide RAM per lane: the write goes in at acceptance, and the read
   // is registered on the edge entering RESP.
   generate
      for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_q;

         // Lane write and registered lane read.
         always_ff @(posedge clk) begin
            if (accept && req_we && !addr_err && req_wstrb[gi]) begin
               mem[req_idx] <= req_wdata[gi*8 +: 8];
            end
            if (rd_en) begin
               rd_q <= mem[rd_idx];
            end
         end

         assign rd_word[gi*8 +: 8] = rd_q;
      end
   endgenerate

endmodule

// File: tb/tb_mc_mem_responder.sv
// Testbench for mc_mem_responder.
// Instance 0 is built with LATENCY=2 and DEPTH=1024; instance 1 with LATENCY=0 and DEPTH=64.
// A word-array reference model predicts the response of every transaction.
module tb_mc_mem_responder;

   localparam int LAT0 = 2;
   localparam int DEP0 = 1024;
   localparam int LAT1 = 0;
   localparam int DEP1 = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [31:0] req_addr  [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_wstrb [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];

   logic [31:0] mdl [2][1024];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mc_mem_responder #(.DATA_W(32), .DEPTH(DEP0), .LATENCY(LAT0)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
   );

   mc_mem_responder #(.DATA_W(32), .DEPTH(DEP1), .LATENCY(LAT1)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? LAT0 : LAT1;
   endfunction

   function automatic int dep_of(input int d);
      return (d == 0) ? DEP0 : DEP1;
   endfunction

   // Drive junk requests while the responder is busy. These must be ignored.
   task automatic drive_junk(input int d);
      req_valid[d] = 1'b1;
      req_we[d]    = 1'b1;
      req_addr[d]  = 32'($urandom_range(0, 15)) << 2;
      req_wdata[d] = $urandom;
      req_wstrb[d] = 4'hF;
   endtask

   // Run one full transaction, holding the response for bp cycles before taking it.
   task automatic txn(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb, input int bp);
      logic        exp_err;
      logic [31:0] exp_rd;
      int          idx;
      int          lat;
      lat     = lat_of(d);
      exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(dep_of(d)));
      exp_rd  = 32'h0;
      idx     = int'(addr >> 2);
      if (!exp_err && !we) exp_rd = mdl[d][idx];
      if (!exp_err && we) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) mdl[d][idx][b*8 +: 8] = wdata[b*8 +: 8];
      end

      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_wstrb[d] = wstrb;
      rsp_ready[d] = 1'b0;
      chk("idle_req_ready", 32'(req_ready[d]), 32'd1);
      chk("idle_rsp_valid", 32'(rsp_valid[d]), 32'd0);

      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         chk("wait_rsp_valid", 32'(rsp_valid[d]), 32'd0);
         chk("wait_req_ready", 32'(req_ready[d]), 32'd0);
         drive_junk(d);
      end

      @(negedge clk);
      chk("resp_valid", 32'(rsp_valid[d]), 32'd1);
      chk("resp_rdata", rsp_rdata[d], exp_rd);
      chk("resp_err", 32'(rsp_err[d]), 32'(exp_err));
      chk("resp_req_ready", 32'(req_ready[d]), 32'd0);
      drive_junk(d);

      for (int k = 0; k < bp; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid[d]), 32'd1);
         chk("bp_rdata", rsp_rdata[d], exp_rd);
         chk("bp_err", 32'(rsp_err[d]), 32'(exp_err));
         chk("bp_req_ready", 32'(req_ready[d]), 32'd0);
         drive_junk(d);
      end

      rsp_ready[d] = 1'b1;
      @(negedge clk);
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b0;
      chk("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("post_req_ready", 32'(req_ready[d]), 32'd1);
      $display("txn inst=%0d we=%0d addr=%h wdata=%h wstrb=%b bp=%0d -> exp_rdata=%h exp_err=%0d",
               d, we, addr, wdata, wstrb, bp, exp_rd, exp_err);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] wd;
      int          acc;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_we[d]    = 1'b0;
         req_addr[d]  = 32'h0;
         req_wdata[d] = 32'h0;
         req_wstrb[d] = 4'h0;
         rsp_ready[d] = 1'b0;
      end

      // Check the outputs while reset is held.
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
         chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
         chk("rst_rsp_err", 32'(rsp_err[d]), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);

      // Full write, then read it back.
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
      // Partial write of lane 1 only.
      txn(0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
      chk("partial_word", mdl[0][4], 32'hDEADAAEF);
      // Misaligned and out-of-range requests, then confirm the array is unchanged.
      txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0);
      txn(0, 1'b0, 32'(4 * DEP0), 32'h0, 4'h0, 0);
      txn(0, 1'b1, 32'h13, 32'h12345678, 4'hF, 0);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
      // Hold the response for 5 cycles of backpressure.
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
      // A write with no strobes still gets a response.
      txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1);
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

      // Fill the first 16 words of both instances.
      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 16; w++)
            txn(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);

      // Reset during the WAIT phase of a write to 0x20; the write must persist.
      wd = $urandom;
      mdl[0][8] = wd;
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b1;
      req_addr[0]  = 32'h20;
      req_wdata[0] = wd;
      req_wstrb[0] = 4'hF;
      @(negedge clk);
      req_valid[0] = 1'b0;
      chk("wait_before_rst", 32'(req_ready[0]), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_wait_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_wait_req_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_release_ready", 32'(req_ready[0]), 32'd1);
      txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

      // Reset while a read response is pending; the response is dropped.
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 32'h10;
      rsp_ready[0] = 1'b0;
      repeat (LAT0 + 1) @(negedge clk);
      req_valid[0] = 1'b0;
      chk("pre_rst_resp_valid", 32'(rsp_valid[0]), 32'd1);
      rst = 1'b0;
      #1;
      chk("rst_resp_valid", 32'(rsp_valid[0]), 32'd0);
      chk("rst_resp_rdata", rsp_rdata[0], 32'd0);
      @(negedge clk);
      rst = 1'b1;
      txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

      // With LATENCY=0, stream reads while rsp_ready is held: one accept every 2 cycles.
      @(negedge clk);
      acc = 0;
      a = 32'h0;
      rsp_ready[1] = 1'b1;
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin
            a = 32'((k / 2) * 4 + 4);
            req_addr[1] = a;
            chk("strm_req_ready", 32'(req_ready[1]), 32'd1);
            chk("strm_idle_valid", 32'(rsp_valid[1]), 32'd0);
            if (req_ready[1]) acc++;
         end else begin
            chk("strm_rsp_valid", 32'(rsp_valid[1]), 32'd1);
            chk("strm_rdata", rsp_rdata[1], mdl[1][a >> 2]);
            chk("strm_busy_ready", 32'(req_ready[1]), 32'd0);
            $display("txn inst=1 stream read addr=%h rdata=%h", a, rsp_rdata[1]);
         end
         @(negedge clk);
      end
      req_valid[1] = 1'b0;
      rsp_ready[1] = 1'b0;
      chk("strm_accepts", 32'(acc), 32'd4);
      @(negedge clk);

      // Random mix of reads, writes and bad addresses.
      for (int i = 0; i < 70; i++) begin
         int d;
         int kind;
         d    = (i < 45) ? 0 : 1;
         kind = $urandom_range(0, 9);
         a    = 32'($urandom_range(0, 15)) << 2;
         if (kind == 0) a = a | 32'($urandom_range(1, 3));
         else if (kind == 1) a = 32'(dep_of(d) + $urandom_range(0, 200)) << 2;
         else if (kind == 2) a = 32'hFFFF_FFFC;
         txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3));
      end
      for (int w = 0; w < 16; w++) begin
         txn(0, 1'b0, 32'(w * 4), 32'h0, 4'h0, 0);
         txn(1, 1'b0, 32'(w * 4), 32'h0, 4'h0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
